// File: rtl/guess_entry.sv
// guess_entry: PS/2 set-2 scan-code decoder feeding letter/counter/level to the level displays
module guess_entry #(
    parameter int WORD_LEN   = 5,
    parameter int NUM_LEVELS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       lvl_won,
    output logic [7:0] letter,
    output logic [7:0] counter,
    output logic [1:0] level,
    output logic       key_strobe
);
    typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BRK} state_t;
    localparam logic [7:0] LEN = 8'(WORD_LEN);
    localparam logic [1:0] TOP = 2'(NUM_LEVELS - 1);
    state_t state;
    logic [7:0] held_key;
    logic [7:0] ascii;
    logic       won_q;
    function automatic logic [7:0] to_ascii(input logic [7:0] c);
        case (c)
            8'h1C: return "A";  8'h32: return "B";  8'h21: return "C";  8'h23: return "D";
            8'h24: return "E";  8'h2B: return "F";  8'h34: return "G";  8'h33: return "H";
            8'h43: return "I";  8'h3B: return "J";  8'h42: return "K";  8'h4B: return "L";
            8'h3A: return "M";  8'h31: return "N";  8'h44: return "O";  8'h4D: return "P";
            8'h15: return "Q";  8'h2D: return "R";  8'h1B: return "S";  8'h2C: return "T";
            8'h3C: return "U";  8'h2A: return "V";  8'h1D: return "W";  8'h22: return "X";
            8'h35: return "Y";  8'h1A: return "Z";
            default: return 8'h00;
        endcase
    endfunction
    always_comb ascii = to_ascii(scan_code);
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            held_key   <= 8'h00;
            won_q      <= 1'b0;
            letter     <= 8'h20;
            counter    <= 8'd0;
            level      <= 2'd0;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            won_q      <= lvl_won;
            if (lvl_won) begin
                state    <= IDLE;
                held_key <= 8'h00;
                letter   <= 8'h20;
                counter  <= 8'd0;
                if (!won_q && level != TOP)
                    level <= level + 2'd1;
            end else if (scan_valid) begin
                case (state)
                    IDLE: begin
                        if (scan_code == 8'hF0)
                            state <= BREAK;
                        else if (scan_code == 8'hE0)
                            state <= EXT;
                        else if (scan_code != held_key) begin
                            held_key <= scan_code;
                            if (ascii != 8'h00) begin
                                if (counter < LEN) begin
                                    letter     <= ascii;
                                    counter    <= counter + 8'd1;
                                    key_strobe <= 1'b1;
                                end
                            end else if (scan_code == 8'h5A) begin
                                if (counter == LEN) begin
                                    counter    <= LEN + 8'd1;
                                    key_strobe <= 1'b1;
                                end
                            end else if (scan_code == 8'h76) begin
                                counter    <= 8'd0;
                                letter     <= 8'h20;
                                key_strobe <= 1'b1;
                            end
                        end
                    end
                    BREAK: begin
                        state <= IDLE;
                        if (scan_code == held_key)
                            held_key <= 8'h00;
                    end
                    EXT:     state <= scan_code == 8'hF0 ? EXT_BRK : IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_guess_entry.sv
// tb_guess_entry: directed and randomized checks of guess_entry against a behavioural model
module tb_guess_entry;
    localparam int WL = 5;
    localparam int NL = 4;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic       lvl_won = 1'b0;
    logic [7:0] letter;
    logic [7:0] counter;
    logic [1:0] level;
    logic       key_strobe;
    int total = 0;
    int bad = 0;
    guess_entry #(.WORD_LEN(WL), .NUM_LEVELS(NL)) dut (
        .clk(clk), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
        .lvl_won(lvl_won), .letter(letter), .counter(counter), .level(level),
        .key_strobe(key_strobe)
    );
    always #5 clk = ~clk;
    byte unsigned codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
        8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
        8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    // model: mode 0=idle 1=after F0 2=after E0 3=after E0 F0
    int m_letter, m_cnt, m_lvl, m_strobe, m_mode, m_held, m_wonq;
    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int letter_of(input int b);
        for (int i = 0; i < 26; i++)
            if (int'(codes[i]) == b) return 65 + i;
        return 0;
    endfunction
    task automatic model_step(input int b, input bit v, input bit w, input bit r);
        if (r) begin
            m_letter = 32; m_cnt = 0; m_lvl = 0; m_strobe = 0; m_mode = 0; m_held = 0; m_wonq = 0;
            return;
        end
        m_strobe = 0;
        if (w) begin
            m_cnt = 0; m_letter = 32; m_mode = 0; m_held = 0;
            if (!m_wonq) m_lvl = (m_lvl + 1 > NL - 1) ? NL - 1 : m_lvl + 1;
        end else if (v) begin
            if (m_mode == 1) begin
                m_mode = 0;
                if (b == m_held) m_held = 0;
            end else if (m_mode == 2) m_mode = (b == 'hF0) ? 3 : 0;
            else if (m_mode == 3) m_mode = 0;
            else if (b == 'hF0) m_mode = 1;
            else if (b == 'hE0) m_mode = 2;
            else if (b != m_held) begin
                m_held = b;
                if (letter_of(b) != 0) begin
                    if (m_cnt < WL) begin m_letter = letter_of(b); m_cnt++; m_strobe = 1; end
                end else if (b == 'h5A) begin
                    if (m_cnt == WL) begin m_cnt = WL + 1; m_strobe = 1; end
                end else if (b == 'h76) begin
                    m_cnt = 0; m_letter = 32; m_strobe = 1;
                end
            end
        end
        m_wonq = w;
    endtask
    task automatic cyc(input logic [7:0] b, input bit v, input bit w, input bit r);
        @(negedge clk);
        scan_code = b; scan_valid = v; lvl_won = w; reset = r;
        @(posedge clk);
        #1;
        model_step(int'(b), v, w, r);
        chk("letter", int'(letter), m_letter);
        chk("counter", int'(counter), m_cnt);
        chk("level", int'(level), m_lvl);
        chk("key_strobe", int'(key_strobe), m_strobe);
    endtask
    task automatic send(input logic [7:0] b);
        cyc(b, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic idle();
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic do_reset();
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        idle();
    endtask
    task automatic type_key(input logic [7:0] b);
        send(b); send(8'hF0); send(b);
    endtask
    task automatic type_logic_enter();
        type_key(8'h4B); type_key(8'h44); type_key(8'h34); type_key(8'h43); type_key(8'h21);
        type_key(8'h1C); send(8'h5A);
    endtask
    initial begin
        do_reset();
        chk("rst_letter", int'(letter), 32'h20);
        chk("rst_counter", int'(counter), 0);
        chk("rst_level", int'(level), 0);
        send(8'h4B);
        chk("t1_strobe", int'(key_strobe), 1);
        chk("t1_letter", int'(letter), 32'h4C);
        send(8'hF0); chk("t1_strobe_off", int'(key_strobe), 0);
        send(8'h4B);
        chk("t1_counter", int'(counter), 1);
        do_reset();
        send(8'h4B); send(8'h4B); send(8'h4B);
        chk("t2_repeat", int'(counter), 1);
        send(8'hF0); send(8'h4B); send(8'h4B);
        chk("t2_counter", int'(counter), 2);
        do_reset();
        type_logic_enter();
        chk("t3_counter", int'(counter), 6);
        chk("t3_letter", int'(letter), 32'h43);
        do_reset();
        type_key(8'h1C); type_key(8'h32); type_key(8'h21);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        chk("t4_ext_counter", int'(counter), 3);
        send(8'h76);
        chk("t4_esc_counter", int'(counter), 0);
        chk("t4_esc_letter", int'(letter), 32'h20);
        do_reset();
        type_logic_enter();
        cyc(8'h1C, 1'b1, 1'b1, 1'b0);
        chk("t5_counter", int'(counter), 0);
        chk("t5_level", int'(level), 1);
        idle();
        chk("t5_dropped", int'(counter), 0);
        cyc(8'h00, 1'b0, 1'b1, 1'b0); idle();
        cyc(8'h00, 1'b0, 1'b1, 1'b0); idle();
        for (int i = 0; i < 4; i++) cyc(8'h00, 1'b0, 1'b1, 1'b0);
        chk("t6_saturate", int'(level), NL - 1);
        idle();
        send(8'hF0);
        do_reset();
        chk("t6_rst_level", int'(level), 0);
        send(8'h1C);
        chk("t6_make_after_rst", int'(letter), 32'h41);
        for (int n = 0; n < 3000; n++) begin
            int sel;
            logic [7:0] b;
            sel = int'($urandom_range(0, 9));
            b = sel < 5 ? 8'(codes[$urandom_range(0, 25)]) : sel == 5 ? 8'hF0 :
                sel == 6 ? 8'hE0 : sel == 7 ? 8'h5A : sel == 8 ? 8'h76 : 8'($urandom);
            cyc(b, $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
